mem_wb_stage: RTL
=================

# mem_wb_stage

Parametrised memory stage for the pipelined core: integrates the data RAM, executes loads and stores, and holds the MEM/WB pipeline register feeding writeback. It generalises data, address and register-index widths and RAM depth. It adds a configurable wait-state FSM that back-pressures earlier stages, a flush input, and a valid bit carried into WB.

## Interface
- DATA_W, 34: datapath width (ALU result, store data, load data, WB outputs)
- ADDR_W, 9: PC width on the pc_plus4 input
- RD_W, 5: destination register index width
- DEPTH, 512: RAM words (power of two, ≥2); AW = $clog2(DEPTH)
- WAIT_STATES, 0: extra cycles per memory access (0..15)
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; synchronous, active-high
- valid_m  in  1  instruction present in MEM
- flush_m  in  1  kill MEM instruction
- reg_write_m / mem_write_m / result_src_m  in  1 each  control bits (result_src_m=1 means load)
- rd_m  in  RD_W  destination register
- pc_plus4_m  in  ADDR_W  PC+4
- alu_result_m  in  DATA_W  address / ALU result
- write_data_m  in  DATA_W  store data
- stall_m  out  1  hold EX/MEM and earlier stages
- valid_w, reg_write_w, result_src_w  out  1 each
- rd_w  out  RD_W
- pc_plus4_w, alu_result_w, read_data_w  out  DATA_W

## Operation
- Memory access (acc) = valid_m & (mem_write_m | result_src_m) & !flush_m.
- RAM: DEPTH × DATA_W, word-addressed by alu_result_m[AW-1:0]. Upper address bits are ignored, so addresses wrap modulo DEPTH. Asynchronous read, synchronous write. Contents are not reset.
- FSM states: IDLE, BUSY; 4-bit counter cnt.
  - IDLE: acc & WAIT_STATES>0 → BUSY, cnt ← WAIT_STATES-1. Otherwise stay in IDLE.
  - BUSY: cnt≠0 → cnt ← cnt-1. cnt==0 → IDLE.
  - flush_m in any state → IDLE.
- stall_m = (IDLE & acc & WAIT_STATES≠0) | (BUSY & cnt≠0) & !flush_m. Combinational.
- Retire edge: any rising edge with stall_m=0 and rst=0.
- At a retire edge, the WB register loads the MEM instruction:
  - valid_w ← valid_m & !flush_m
  - reg_write_w ← reg_write_m & valid_w
  - result_src_w, rd_w, alu_result_w loaded from the corresponding inputs
  - pc_plus4_w ← zero-extended pc_plus4_m
  - read_data_w ← RAM[addr]
- Store writes RAM exactly once, at the retire edge, only if valid_m & !flush_m.
- While stall_m=1, the WB register takes a bubble: valid_w ← 0, reg_write_w ← 0, data fields hold.
- Upstream holds all _m inputs stable while stall_m=1.
- mem_write_m & result_src_m together: store performed; read_data_w gets the pre-write word.
- valid_m=0: bubble into WB, no RAM write, FSM stays IDLE.
- flush_m while BUSY: access aborted, no RAM write, bubble into WB, back to IDLE next cycle.

## Timing
- Reset (rst=1 at edge): state IDLE, cnt 0. valid_w, reg_write_w, result_src_w, rd_w, pc_plus4_w, alu_result_w, read_data_w all 0. stall_m=0 in the cycle after reset.
- Non-memory instruction, or any instruction with WAIT_STATES=0: 1 cycle in MEM; WB outputs valid on the next edge.
- Memory access with WAIT_STATES=N>0: N+1 cycles in MEM. stall_m is high for exactly the first N cycles. WB outputs update at the end of cycle N+1.
- Back-to-back accesses: the second access's stall starts in the cycle right after the first retires; no idle gap.
- Store followed by load to same address: the load sees the stored value (write at the earlier retire edge).

## Configuration
- MEM_STALL_CNT_EN defined:
  - adds output perf_stall_cnt [15:0]
  - increments on every cycle with stall_m=1
  - saturates at 16'hFFFF
  - cleared by rst
- Not defined: port and counter absent; behaviour otherwise identical.

## Test plan
- rst=1 for 2 cycles mid-access (BUSY) → all WB outputs 0, stall_m=0, no RAM write, FSM IDLE.
- WAIT_STATES=0: store 34'h2_0000_0ABC at addr 5, then load addr 5 → read_data_w=34'h2_0000_0ABC, result_src_w=1, one cycle each, stall_m never high.
- WAIT_STATES=3: load → stall_m high 3 cycles; WB bubbles (valid_w=0) during those cycles; valid_w=1 on the 4th edge.
- Address wrap, DEPTH=512: store to alu_result 34'h205, load addr 5 → same word returned.
- flush_m asserted during 2nd BUSY cycle of a store → RAM unchanged, valid_w=0, stall_m drops in the flush cycle.
- MEM_STALL_CNT_EN defined, WAIT_STATES=2, three back-to-back loads → perf_stall_cnt=6.

Source files
------------

// File: rtl/mem_wb_stage.sv
// mem_wb_stage
//   Memory stage of the pipelined core. It holds the data RAM, performs
//   loads and stores, and owns the MEM/WB pipeline register that feeds
//   writeback. An optional wait-state FSM back-pressures the earlier
//   stages through stall_m while a RAM access is in progress.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   valid_m, flush_m  instruction present / kill it
//   reg_write_m, mem_write_m, result_src_m (1 = load), rd_m,
//   pc_plus4_m, alu_result_m (address or ALU result), write_data_m
//   stall_m           hold EX/MEM and earlier stages (combinational)
//   valid_w, reg_write_w, result_src_w, rd_w,
//   pc_plus4_w, alu_result_w, read_data_w   MEM/WB register outputs
//   perf_stall_cnt    saturating count of stall cycles (MEM_STALL_CNT_EN)
//
// Build option
//   MEM_STALL_CNT_EN  adds perf_stall_cnt[15:0]
module mem_wb_stage #(
  parameter int DATA_W      = 34,
  parameter int ADDR_W      = 9,
  parameter int RD_W        = 5,
  parameter int DEPTH       = 512,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_m,
  input  logic              flush_m,
  input  logic              reg_write_m,
  input  logic              mem_write_m,
  input  logic              result_src_m,
  input  logic [RD_W-1:0]   rd_m,
  input  logic [ADDR_W-1:0] pc_plus4_m,
  input  logic [DATA_W-1:0] alu_result_m,
  input  logic [DATA_W-1:0] write_data_m,
  output logic              stall_m,
  output logic              valid_w,
  output logic              reg_write_w,
  output logic              result_src_w,
  output logic [RD_W-1:0]   rd_w,
  output logic [DATA_W-1:0] pc_plus4_w,
  output logic [DATA_W-1:0] alu_result_w,
  output logic [DATA_W-1:0] read_data_w
`ifdef MEM_STALL_CNT_EN
  ,
  output logic [15:0]       perf_stall_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WS    = 4'(WAIT_STATES);
  // Only used when WAIT_STATES > 0, so the wrap at 0 is harmless.
  localparam logic [3:0] WS_M1 = 4'(WAIT_STATES - 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t            r_state, w_state_nxt;
  logic [3:0]        r_cnt, w_cnt_nxt;
  logic              w_acc;
  logic              w_valid_in;
  logic              w_we;
  logic [AW-1:0]     w_addr;
  logic [DATA_W-1:0] w_rdata;
  logic [DATA_W-1:0] r_mem [DEPTH];

  assign w_acc      = valid_m & (mem_write_m | result_src_m) & ~flush_m;
  assign w_valid_in = valid_m & ~flush_m;
  assign w_addr     = alu_result_m[AW-1:0];

  // Upper address bits are deliberately dropped: addresses wrap mod DEPTH.
  logic w_unused;
  assign w_unused = ^alu_result_m;

  // Wait-state FSM. cnt holds the number of stall cycles still to come
  // after the current one; the access retires in the BUSY cycle where
  // cnt has reached zero.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    stall_m     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_acc && (WS != 4'd0)) begin
          w_state_nxt = S_BUSY;
          w_cnt_nxt   = WS_M1;
          stall_m     = 1'b1;
        end
      end
      S_BUSY: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
          stall_m   = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // A flush aborts the access at once and releases the pipeline.
    if (flush_m) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = 4'd0;
      stall_m     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Stores commit only on the retire edge, so a stalled or flushed access
  // never touches the array.
  assign w_we = ~rst & ~stall_m & valid_m & mem_write_m & ~flush_m;

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_addr] <= write_data_m;
  end

  // Asynchronous read: a load+store pair returns the pre-write word.
  assign w_rdata = r_mem[w_addr];

  // MEM/WB register: bubble while stalled, load on retire.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_w      <= 1'b0;
      reg_write_w  <= 1'b0;
      result_src_w <= 1'b0;
      rd_w         <= '0;
      pc_plus4_w   <= '0;
      alu_result_w <= '0;
      read_data_w  <= '0;
    end else if (stall_m) begin
      valid_w     <= 1'b0;
      reg_write_w <= 1'b0;
    end else begin
      valid_w      <= w_valid_in;
      reg_write_w  <= reg_write_m & w_valid_in;
      result_src_w <= result_src_m;
      rd_w         <= rd_m;
      pc_plus4_w   <= DATA_W'(pc_plus4_m);
      alu_result_w <= alu_result_m;
      read_data_w  <= w_rdata;
    end
  end

`ifdef MEM_STALL_CNT_EN
  logic [15:0] r_perf;
  always_ff @(posedge clk) begin
    if (rst)                             r_perf <= 16'd0;
    else if (stall_m && r_perf != 16'hFFFF) r_perf <= r_perf + 16'd1;
  end
  assign perf_stall_cnt = r_perf;
`endif

endmodule
